// File: rtl/cdc_pkg.sv
// Types and defaults shared by both ends of the toggle req/ack CDC handshake.
package cdc_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_DATA_W      = 8;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchroniser; asynchronous active-high reset clears every stage.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/cdc_handshake_receiver.sv
// Destination endpoint of the toggle req/ack handshake: captures the held source word,
// presents it on valid/ready and returns an ack toggle once per accepted request.
module cdc_handshake_receiver
  import cdc_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int ACK_EARLY   = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk_dst,
  input  logic              rst,
  input  logic              req_toggle_async,
  input  logic [DATA_W-1:0] data_async,
  output logic              ack_toggle,
  output logic [DATA_W-1:0] data_dst,
  output logic              valid_dst,
  input  logic              ready_dst,
  output logic              proto_err,
  output logic [CNT_W-1:0]  xfer_count
);

  localparam bit EARLY = (ACK_EARLY != 0);

  logic              req_sync_s;
  logic              req_q_r;
  logic              req_event_s;
  logic              hs_s;
  occ_e              state_r, state_nxt_s;
  logic [DATA_W-1:0] skid_r, skid_nxt_s, data_nxt_s;
  logic              valid_nxt_s, ack_nxt_s, perr_nxt_s;
  logic              ack_pending_r, pend_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk_dst),
    .rst (rst),
    .d   (req_toggle_async),
    .q   (req_sync_s)
  );

  assign req_event_s = req_sync_s ^ req_q_r;
  assign hs_s        = valid_dst & ready_dst;

  // Occupancy, buffer and ack bookkeeping; a handshake frees a slot before a same-cycle capture
  always_comb begin
    state_nxt_s = state_r;
    data_nxt_s  = data_dst;
    skid_nxt_s  = skid_r;
    valid_nxt_s = valid_dst;
    ack_nxt_s   = ack_toggle;
    pend_nxt_s  = ack_pending_r;
    perr_nxt_s  = proto_err;
    if (hs_s) begin
      cnt_nxt_s = xfer_count + CNT_W'(1);
    end else begin
      cnt_nxt_s = xfer_count;
    end
    case (state_r)
      EMPTY: begin
        if (req_event_s) begin
          data_nxt_s  = data_async;
          valid_nxt_s = 1'b1;
          state_nxt_s = ONE;
          ack_nxt_s   = ack_toggle ^ EARLY;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      ONE: begin
        if (hs_s && req_event_s) begin
          data_nxt_s = data_async;
          ack_nxt_s  = ~ack_toggle;
        end else if (hs_s) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = EMPTY;
          ack_nxt_s   = ack_toggle ^ ~EARLY;
        end else if (req_event_s) begin
          if (EARLY) begin
            skid_nxt_s  = data_async;
            state_nxt_s = TWO;
            pend_nxt_s  = 1'b1;
          end else begin
            perr_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ONE;
        end
      end
      TWO: begin
        // The deferred ack goes out on the handshake that frees the second slot
        if (hs_s && req_event_s) begin
          data_nxt_s = skid_r;
          skid_nxt_s = data_async;
          ack_nxt_s  = ack_toggle ^ ack_pending_r;
          pend_nxt_s = 1'b1;
        end else if (hs_s) begin
          data_nxt_s  = skid_r;
          state_nxt_s = ONE;
          ack_nxt_s   = ack_toggle ^ ack_pending_r;
          pend_nxt_s  = 1'b0;
        end else if (req_event_s) begin
          perr_nxt_s = 1'b1;
        end else begin
          state_nxt_s = TWO;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
        valid_nxt_s = 1'b0;
        pend_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_dst or posedge rst) begin
    if (rst) begin
      req_q_r       <= 1'b0;
      state_r       <= EMPTY;
      data_dst      <= {DATA_W{1'b0}};
      skid_r        <= {DATA_W{1'b0}};
      valid_dst     <= 1'b0;
      ack_toggle    <= 1'b0;
      ack_pending_r <= 1'b0;
      proto_err     <= 1'b0;
      xfer_count    <= {CNT_W{1'b0}};
    end else begin
      req_q_r       <= req_sync_s;
      state_r       <= state_nxt_s;
      data_dst      <= data_nxt_s;
      skid_r        <= skid_nxt_s;
      valid_dst     <= valid_nxt_s;
      ack_toggle    <= ack_nxt_s;
      ack_pending_r <= pend_nxt_s;
      proto_err     <= perr_nxt_s;
      xfer_count    <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_receiver.sv
// Directed bench: instance A (ack on accept, 4-bit counter) and instance B (early ack).
module tb_cdc_handshake_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_req = 1'b0, a_ready = 1'b0;
  logic [7:0]  a_data = 8'h00;
  logic        a_ack, a_valid, a_perr;
  logic [7:0]  a_ddst;
  logic [3:0]  a_cnt;

  logic        b_req = 1'b0, b_ready = 1'b0;
  logic [7:0]  b_data = 8'h00;
  logic        b_ack, b_valid, b_perr;
  logic [7:0]  b_ddst;
  logic [15:0] b_cnt;

  int checks_total  = 0;
  int checks_passed = 0;
  logic exp_ack;

  always #5 clk = ~clk;

  cdc_handshake_receiver #(.DATA_W(8), .SYNC_STAGES(2), .ACK_EARLY(0), .CNT_W(4)) u_dut_a (
    .clk_dst(clk), .rst(rst), .req_toggle_async(a_req), .data_async(a_data),
    .ack_toggle(a_ack), .data_dst(a_ddst), .valid_dst(a_valid), .ready_dst(a_ready),
    .proto_err(a_perr), .xfer_count(a_cnt)
  );

  cdc_handshake_receiver #(.DATA_W(8), .SYNC_STAGES(2), .ACK_EARLY(1), .CNT_W(16)) u_dut_b (
    .clk_dst(clk), .rst(rst), .req_toggle_async(b_req), .data_async(b_data),
    .ack_toggle(b_ack), .data_dst(b_ddst), .valid_dst(b_valid), .ready_dst(b_ready),
    .proto_err(b_perr), .xfer_count(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wait_a_valid(input string tag);
    int n = 0;
    while (a_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check(tag, {31'd0, a_valid}, 32'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    // reset with random input activity
    for (int i = 0; i < 3; i++) begin
      a_req = 1'($urandom); b_req = 1'($urandom);
      a_data = 8'($urandom); b_data = 8'($urandom);
      a_ready = 1'($urandom); b_ready = 1'($urandom);
      tick();
      check("rst_a_outs", {17'd0, a_ack, a_valid, a_perr, a_ddst, a_cnt}, 32'd0);
      check("rst_b_outs", {5'd0, b_ack, b_valid, b_perr, b_ddst, b_cnt}, 32'd0);
    end
    a_req = 1'b0; b_req = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    a_data = 8'h00; b_data = 8'h00;
    rst = 1'b0;
    repeat (5) tick();
    check("idle_a", {30'd0, a_valid, a_ack}, 32'd0);
    check("idle_b", {30'd0, b_valid, b_ack}, 32'd0);

    // single transfer, A, ready high
    a_data = 8'hA5; a_ready = 1'b1; a_req = 1'b1;
    tick();
    check("lat_k", {31'd0, a_valid}, 32'd0);
    tick();
    check("lat_k1", {31'd0, a_valid}, 32'd0);
    tick();
    check("single_valid", {31'd0, a_valid}, 32'd1);
    check("single_data", {24'd0, a_ddst}, 32'hA5);
    check("single_ack_pre", {31'd0, a_ack}, 32'd0);
    tick();
    check("single_ack", {31'd0, a_ack}, 32'd1);
    check("single_cnt", {28'd0, a_cnt}, 32'd1);
    check("single_valid_off", {31'd0, a_valid}, 32'd0);

    // backpressure, A
    a_ready = 1'b0; a_data = 8'h3C; a_req = 1'b0;
    repeat (3) tick();
    check("bp_valid", {31'd0, a_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {23'd0, a_ack, a_ddst}, {23'd0, 1'b1, 8'h3C});
      tick();
    end
    a_ready = 1'b1;
    check("bp_ack_pre", {31'd0, a_ack}, 32'd1);
    tick();
    check("bp_ack", {31'd0, a_ack}, 32'd0);
    check("bp_cnt", {28'd0, a_cnt}, 32'd2);
    check("bp_valid_off", {31'd0, a_valid}, 32'd0);

    // protocol violation, A
    a_ready = 1'b0; a_data = 8'h5A; a_req = 1'b1;
    repeat (3) tick();
    check("pe_first", {23'd0, a_valid, a_ddst}, {23'd0, 1'b1, 8'h5A});
    a_data = 8'h77; a_req = 1'b0;
    repeat (3) tick();
    check("pe_flag", {31'd0, a_perr}, 32'd1);
    check("pe_data", {24'd0, a_ddst}, 32'h5A);
    check("pe_noack", {31'd0, a_ack}, 32'd0);
    a_ready = 1'b1;
    tick();
    check("pe_ack", {31'd0, a_ack}, 32'd1);
    check("pe_sticky", {31'd0, a_perr}, 32'd1);
    check("pe_cnt", {28'd0, a_cnt}, 32'd3);
    tick();
    check("pe_dropped", {30'd0, a_valid, a_perr}, {30'd0, 1'b0, 1'b1});

    // early ack, B
    b_ready = 1'b0; b_data = 8'h11; b_req = 1'b1;
    repeat (3) tick();
    check("early_data1", {23'd0, b_valid, b_ddst}, {23'd0, 1'b1, 8'h11});
    check("early_ack1", {31'd0, b_ack}, 32'd1);
    b_data = 8'h22; b_req = 1'b0;
    repeat (3) tick();
    check("early_skid_noack", {31'd0, b_ack}, 32'd1);
    check("early_pending", {31'd0, u_dut_b.ack_pending_r}, 32'd1);
    check("early_hold", {24'd0, b_ddst}, 32'h11);
    check("early_noerr", {31'd0, b_perr}, 32'd0);
    b_ready = 1'b1;
    tick();
    check("early_data2", {23'd0, b_valid, b_ddst}, {23'd0, 1'b1, 8'h22});
    check("early_ack2", {31'd0, b_ack}, 32'd0);
    check("early_cnt1", {16'd0, b_cnt}, 32'd1);
    tick();
    check("early_empty", {31'd0, b_valid}, 32'd0);
    check("early_cnt2", {16'd0, b_cnt}, 32'd2);
    check("early_ack_final", {31'd0, b_ack}, 32'd0);

    // reset clears sticky error, then counter wrap on A
    a_req = 1'b0; a_ready = 1'b1;
    rst = 1'b1;
    tick();
    check("rst2_a", {27'd0, a_perr, a_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    exp_ack = 1'b0;
    for (int i = 0; i < 17; i++) begin
      a_data = 8'(i + 1);
      a_req = ~a_req;
      exp_ack = ~exp_ack;
      wait_a_valid("wrap_timeout");
      check("wrap_data", {24'd0, a_ddst}, i + 1);
      tick();
      check("wrap_ack", {31'd0, a_ack}, {31'd0, exp_ack});
    end
    check("wrap_cnt", {28'd0, a_cnt}, 32'd1);
    check("wrap_ack_final", {31'd0, a_ack}, 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_receiver.md
Name: cdc_handshake_receiver

Overview:
- Destination-side endpoint of the toggle-request / toggle-acknowledge CDC handshake, located entirely in the destination clock domain.
- Synchronises an incoming request toggle and captures a data bus that the source holds stable.
- Presents each captured word on a valid/ready interface and returns an acknowledge toggle, which the source domain synchronises itself.
- Pairs with a source-side sender that toggles req only after seeing the previous ack toggle.

Parameters:
- DATA_W, 8: width of the transferred word.
- SYNC_STAGES, 2: flops in the req synchroniser; legal values 2..4.
- ACK_EARLY, 0:
  - 0: ack toggles when the consumer accepts the word (single-entry buffer).
  - 1: ack toggles at capture whenever a slot remains free (two-entry buffer).
- CNT_W, 16: width of the transfer counter.

Ports:
- clk_dst  in  1  destination clock.
- rst  in  1  asynchronous, active-high reset.
- req_toggle_async  in  1  request toggle from the source domain; unsynchronised.
- data_async  in  DATA_W  source data; stable from the req toggle until the matching ack toggle is seen by the source.
- ack_toggle  out  1  registered acknowledge toggle returned to the source domain.
- data_dst  out  DATA_W  output word.
- valid_dst  out  1  data_dst holds a valid word.
- ready_dst  in  1  consumer accepts data_dst when valid_dst && ready_dst.
- proto_err  out  1  sticky flag: request arrived with no free slot.
- xfer_count  out  CNT_W  number of words accepted by the consumer; wraps.

Behaviour:
- Reset values (asynchronous on rst): all synchroniser flops 0, req_q 0, ack_toggle 0, data_dst 0, valid_dst 0, skid buffer empty and data 0, proto_err 0, xfer_count 0, ack_pending 0.
- Request detection:
  - req_sync is the last synchroniser stage; req_q registers req_sync.
  - req_event = req_sync ^ req_q, combinational, high for exactly one cycle per toggle.
- Latency: a toggle meeting setup at clk_dst edge k raises valid_dst after edge k+SYNC_STAGES (3 edges for the default).
- Occupancy: states EMPTY, ONE, TWO; TWO is reachable only when ACK_EARLY=1. Enum lives in the package.
- Capture on req_event:
  - EMPTY: data_async -> data_dst, valid_dst=1, go to ONE.
  - ONE, ACK_EARLY=1: data_async -> skid, go to TWO.
  - ONE, ACK_EARLY=0: no free slot. Set proto_err, drop the data, state unchanged.
  - TWO: no free slot. Set proto_err, drop the data, state unchanged.
- Consumer handshake (valid_dst && ready_dst):
  - xfer_count increments, wrapping at 2^CNT_W.
  - From ONE: valid_dst=0, go to EMPTY.
  - From TWO: skid -> data_dst, valid_dst stays 1, go to ONE.
- Simultaneous handshake and req_event in the same cycle:
  - ONE: handshake takes precedence. The new word loads data_dst directly, valid_dst stays 1, state stays ONE, no proto_err.
  - TWO: the skid word moves to data_dst and the new word loads the skid. State stays TWO, no proto_err.
- ack_toggle rules, with at most one flip per cycle:
  - ACK_EARLY=0: flips on the cycle of each consumer handshake.
  - ACK_EARLY=1, capture from EMPTY: flips on the capture cycle.
  - ACK_EARLY=1, capture into TWO: sets ack_pending. The flip happens on the handshake that frees a slot, then ack_pending clears.
  - Both modes: exactly one flip per accepted req_event, so ack count equals request count.
- Dropped requests are never acknowledged, and the source stalls. proto_err flags this; the system must reset to recover.
- proto_err clears only on rst.
- data_dst is stable while valid_dst && !ready_dst.
- A consumer may hold ready_dst high continuously; this gives one word per handshake with no bubbles beyond the synchroniser latency.
- Reset mid-transfer discards the buffer. The source side must be reset in the same event.

Decomposition:
- Shared package cdc_pkg:
  - occupancy enum {EMPTY, ONE, TWO}.
  - constants DEFAULT_SYNC_STAGES=2 and DEFAULT_DATA_W=8.
  - Reused by the matching sender.
- Sub-module cdc_sync_bit: parameterised N-stage single-bit synchroniser with asynchronous active-high reset to 0. Shared with the sender's ack synchroniser.

Test Plan:
- Reset then idle: rst high 3 cycles, inputs toggling at random -> all outputs 0 throughout reset. After release with req constant, valid_dst and ack_toggle stay 0.
- Single transfer, ACK_EARLY=0, ready_dst=1:
  - Stimulus: data_async=8'hA5, req toggles 0->1 before edge k.
  - Response: valid_dst=1 and data_dst=8'hA5 after edge k+2. Handshake on that cycle, so ack_toggle=1 after edge k+3 and xfer_count=1.
- Backpressure, ACK_EARLY=0:
  - Stimulus: ready_dst=0 for 10 cycles after valid_dst rises.
  - Response: data_dst held, ack_toggle unchanged. It flips one cycle after ready_dst rises.
- ACK_EARLY=1, two words 8'h11 and 8'h22, ready_dst=0:
  - First capture: ack flips.
  - Second word goes to the skid, ack_pending=1, no flip.
  - Raise ready_dst: data_dst=8'h11 then 8'h22, a second ack flip on the first handshake, xfer_count=2.
- Protocol violation, ACK_EARLY=0: second req toggle while valid_dst=1 and ready_dst=0 -> proto_err=1 (sticky), data_dst unchanged, no ack flip.
- Counter wrap with CNT_W=4: 17 back-to-back transfers -> xfer_count=1, ack_toggle=1 (17 flips).
